fetch_decode: RTL and testbench
===============================

FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter IW, default 9: instruction word width; opcode is bits [IW-1:IW-4], operand is bits [IW-5:0]; IW >= 5.
REQ-002 SHALL have parameter PCW, default 10: program counter width.
REQ-003 SHALL have parameter START_PC, default 0: PC loaded on Start.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have port CLK  input  1  rising-edge clock.
REQ-006 SHALL have port Reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port Start  input  1  begin or restart fetch at START_PC.
REQ-008 SHALL have port imem_addr  output  PCW  instruction memory address; equals the internal PC.
REQ-009 SHALL have port imem_data  input  IW  combinational-read instruction at imem_addr.
REQ-010 SHALL have port stall_in  input  1  downstream not ready; hold all outputs.
REQ-011 SHALL have port branch_taken  input  1  redirect request from execute.
REQ-012 SHALL have port branch_target  input  PCW  redirect address.
REQ-013 SHALL have port valid_out  output  1  decoded instruction presented this cycle.
REQ-014 SHALL have port opcode_out  output  4  decoded opcode, using the team's ADD..RST opcode map.
REQ-015 SHALL have port operand_out  output  IW-4  operand field.
REQ-016 SHALL have port pc_out  output  PCW  address of the presented instruction.
REQ-017 SHALL have port halted  output  1  high in HALT state.
REQ-018 SHALL have port illegal_op  output  1  presented opcode is 4'b1101 or 4'b1110.

Function
REQ-019 SHALL implement states IDLE, RUN, HALT; Reset forces IDLE.
REQ-020 SHALL move IDLE->RUN on Start and load PC=START_PC; Start in HALT behaves the same; Start in RUN restarts at START_PC and squashes the output (valid_out=0 next cycle).
REQ-021 In RUN with stall_in=0, SHALL register imem_data and PC into the output registers, set valid_out=1, and increment PC; latency is 1 cycle from address to output.
REQ-022 SHALL wrap the PC from 2^PCW-1 to 0.
REQ-023 With stall_in=1, SHALL hold PC and all outputs unchanged and ignore branch_taken.
REQ-024 With branch_taken=1, stall_in=0 and valid_out=1, SHALL load PC=branch_target and drive valid_out=0 the next cycle (one-bubble squash); branch_taken with valid_out=0 is ignored.
REQ-025 When the presented opcode is 4'b1111 (RST), valid_out=1 and stall_in=0, SHALL enter HALT next cycle with valid_out=0 and halted=1; a branch in the same cycle is ignored.
REQ-026 In IDLE and HALT, SHALL hold PC and keep valid_out=0.
REQ-027 SHALL drive illegal_op combinationally from opcode_out, qualified by valid_out.

Reset
REQ-028 Reset SHALL have priority over Start, stall_in and branch_taken.
REQ-029 Reset SHALL set state=IDLE, PC=START_PC, valid_out=0, opcode_out=0, operand_out=0, pc_out=0, halted=0 and the trap flag to 0, including mid-RUN and mid-stall.

Configuration
REQ-030 With macro FETCH_ILLEGAL_TRAP_EN defined, an illegal opcode presented with valid_out=1 and stall_in=0 SHALL enter HALT; illegal_op SHALL then stay high until Reset or Start.
REQ-031 Without FETCH_ILLEGAL_TRAP_EN, illegal opcodes SHALL pass through as normal instructions, and illegal_op SHALL be only the combinational flag.

Verification
REQ-032 Reset, Start, memory holds 0x001,0x002,0x003 at 0..2 -> cycles 1..3 show valid_out=1, pc_out=0,1,2, operand_out=1,2,3.
REQ-033 stall_in=1 for 3 cycles while pc_out=1 -> outputs frozen at pc_out=1 and imem_addr=2; output resumes with pc_out=2.
REQ-034 branch_taken=1 with branch_target=0x3F0 while pc_out=5 -> next cycle valid_out=0; following cycle pc_out=0x3F0.
REQ-035 PCW=4, sequential run -> pc_out goes 14,15,0,1.
REQ-036 Opcode 1111 presented at pc_out=7 -> next cycle halted=1 and valid_out=0; Start -> pc_out=0 two cycles later.
REQ-037 Opcode 1101 presented -> illegal_op=1; with FETCH_ILLEGAL_TRAP_EN, halted=1 next cycle and illegal_op held; without it, fetch continues; Reset mid-trap clears all outputs.

Source files
------------

// File: rtl/fetch_decode.sv
// Fetch/decode front end: IDLE/RUN/HALT sequencer, 1-cycle imem fetch, branch squash, RST halt.
// Optional macro FETCH_ILLEGAL_TRAP_EN: illegal opcodes halt fetch and latch illegal_op.
module fetch_decode #(
  parameter int unsigned IW       = 9,
  parameter int unsigned PCW      = 10,
  parameter int unsigned START_PC = 0
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            Start,
  output logic [PCW-1:0]  imem_addr,
  input  logic [IW-1:0]   imem_data,
  input  logic            stall_in,
  input  logic            branch_taken,
  input  logic [PCW-1:0]  branch_target,
  output logic            valid_out,
  output logic [3:0]      opcode_out,
  output logic [IW-5:0]   operand_out,
  output logic [PCW-1:0]  pc_out,
  output logic            halted,
  output logic            illegal_op
);

  localparam int unsigned OPNDW = IW - 4;
  localparam logic [PCW-1:0] START_PC_L = PCW'(START_PC);
  localparam logic [3:0] OP_RST = 4'b1111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [3:0]       opcode_q, opcode_d;
  logic [OPNDW-1:0] operand_q, operand_d;
  logic [PCW-1:0]   pc_out_q, pc_out_d;
  logic             halted_q, halted_d;
  logic             trap_q, trap_d;
  logic             illegal_raw_c;

  assign illegal_raw_c = (opcode_q == 4'b1101) || (opcode_q == 4'b1110);

  // Next-state and output-register logic
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    pc_out_d  = pc_out_q;
    halted_d  = halted_q;
    trap_d    = trap_q;
    if (Start) begin
      state_d  = ST_RUN;
      pc_d     = START_PC_L;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      trap_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall_in) begin
            if (valid_q && (opcode_q == OP_RST)) begin
              state_d  = ST_HALT;
              valid_d  = 1'b0;
              halted_d = 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
            end else if (valid_q && illegal_raw_c) begin
              state_d  = ST_HALT;
              valid_d  = 1'b0;
              halted_d = 1'b1;
              trap_d   = 1'b1;
`endif
            end else if (valid_q && branch_taken) begin
              pc_d    = branch_target;
              valid_d = 1'b0;
            end else begin
              valid_d   = 1'b1;
              opcode_d  = imem_data[IW-1 -: 4];
              operand_d = imem_data[OPNDW-1:0];
              pc_out_d  = pc_q;
              pc_d      = pc_q + PCW'(1);
            end
          end
        end
        ST_IDLE, ST_HALT: valid_d = 1'b0;
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= START_PC_L;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      pc_out_q  <= '0;
      halted_q  <= 1'b0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      pc_out_q  <= pc_out_d;
      halted_q  <= halted_d;
      trap_q    <= trap_d;
    end
  end

  assign imem_addr   = pc_q;
  assign valid_out   = valid_q;
  assign opcode_out  = opcode_q;
  assign operand_out = operand_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;
  // trap_q stays 0 unless the trap feature is compiled in
  assign illegal_op  = (valid_q && illegal_raw_c) || trap_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: default instance plus a PCW=4 instance for PC wrap.
module tb_fetch_decode;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       stall_in = 1'b0;
  logic       branch_taken = 1'b0;
  logic [9:0] branch_target = '0;
  logic [9:0] imem_addr;
  logic [8:0] imem_data;
  logic       valid_out, halted, illegal_op;
  logic [3:0] opcode_out;
  logic [4:0] operand_out;
  logic [9:0] pc_out;

  logic [3:0] imem_addr2, pc_out2;
  logic [8:0] imem_data2;
  logic       valid_out2, halted2, illegal_op2;
  logic [3:0] opcode_out2;
  logic [4:0] operand_out2;

  logic [8:0] imem [0:1023];
  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  assign imem_data  = imem[imem_addr];
  assign imem_data2 = 9'(imem_addr2);

  fetch_decode dut (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall_in(stall_in), .branch_taken(branch_taken), .branch_target(branch_target),
    .valid_out(valid_out), .opcode_out(opcode_out), .operand_out(operand_out),
    .pc_out(pc_out), .halted(halted), .illegal_op(illegal_op)
  );

  fetch_decode #(.PCW(4)) dut_w (
    .CLK(CLK), .Reset(Reset), .Start(Start),
    .imem_addr(imem_addr2), .imem_data(imem_data2),
    .stall_in(1'b0), .branch_taken(1'b0), .branch_target(4'd0),
    .valid_out(valid_out2), .opcode_out(opcode_out2), .operand_out(operand_out2),
    .pc_out(pc_out2), .halted(halted2), .illegal_op(illegal_op2)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = 9'h000;
    imem[0]     = 9'h001;
    imem[1]     = 9'h002;
    imem[2]     = 9'h003;
    imem[7]     = 9'h1E0;
    imem[10'h3F0] = 9'h010;
    imem[10'h3F1] = 9'h1A5;

    // PC wrap on the 4-bit instance
    step();
    Reset = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("wrap_14", 32'(pc_out2), 32'd14);
    step();
    chk("wrap_15", 32'(pc_out2), 32'd15);
    step();
    chk("wrap_0", 32'(pc_out2), 32'd0);
    step();
    chk("wrap_1", 32'(pc_out2), 32'd1);
    chk("wrap_valid", 32'(valid_out2), 32'd1);

    // Reset state
    Reset = 1'b1;
    step();
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_opcode", 32'(opcode_out), 32'd0);
    chk("rst_operand", 32'(operand_out), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);

    // Start and sequential fetch
    Reset = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("start_valid", 32'(valid_out), 32'd0);
    chk("start_addr", 32'(imem_addr), 32'd0);
    step();
    chk("seq0_valid", 32'(valid_out), 32'd1);
    chk("seq0_pc", 32'(pc_out), 32'd0);
    chk("seq0_opnd", 32'(operand_out), 32'd1);
    step();
    chk("seq1_pc", 32'(pc_out), 32'd1);
    chk("seq1_opnd", 32'(operand_out), 32'd2);

    // Stall holds everything
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", 32'(pc_out), 32'd1);
      chk("stall_addr", 32'(imem_addr), 32'd2);
      chk("stall_valid", 32'(valid_out), 32'd1);
    end
    stall_in = 1'b0;
    step();
    chk("resume_pc", 32'(pc_out), 32'd2);
    chk("resume_opnd", 32'(operand_out), 32'd3);
    step();
    step();
    step();
    chk("pre_br_pc", 32'(pc_out), 32'd5);

    // Branch squash; a branch during the bubble is ignored
    branch_taken = 1'b1; branch_target = 10'h3F0;
    step();
    chk("br_bubble", 32'(valid_out), 32'd0);
    chk("br_addr", 32'(imem_addr), 32'h3F0);
    branch_target = 10'h100;
    step();
    branch_taken = 1'b0;
    chk("br_pc", 32'(pc_out), 32'h3F0);
    chk("br_valid", 32'(valid_out), 32'd1);
    chk("br_opnd", 32'(operand_out), 32'h10);

    // Illegal opcode
    step();
    chk("ill_pc", 32'(pc_out), 32'h3F1);
    chk("ill_opcode", 32'(opcode_out), 32'hD);
    chk("ill_flag", 32'(illegal_op), 32'd1);
    step();
`ifdef FETCH_ILLEGAL_TRAP_EN
    chk("trap_halted", 32'(halted), 32'd1);
    chk("trap_valid", 32'(valid_out), 32'd0);
    chk("trap_flag", 32'(illegal_op), 32'd1);
    step();
    chk("trap_hold_flag", 32'(illegal_op), 32'd1);
    chk("trap_hold_addr", 32'(imem_addr), 32'h3F2);
`else
    chk("pass_pc", 32'(pc_out), 32'h3F2);
    chk("pass_valid", 32'(valid_out), 32'd1);
    chk("pass_flag", 32'(illegal_op), 32'd0);
    chk("pass_halted", 32'(halted), 32'd0);
`endif
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_flag", 32'(illegal_op), 32'd0);
    chk("midrst_pc", 32'(pc_out), 32'd0);
    chk("midrst_opcode", 32'(opcode_out), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);

    // RST opcode halts; branch in same cycle ignored
    Start = 1'b1;
    step();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    step();
    chk("rst_op_pc", 32'(pc_out), 32'd7);
    chk("rst_op_code", 32'(opcode_out), 32'hF);
    branch_taken = 1'b1; branch_target = 10'h200;
    step();
    branch_taken = 1'b0;
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_valid", 32'(valid_out), 32'd0);
    chk("halt_addr", 32'(imem_addr), 32'd8);
    step();
    chk("halt_hold_addr", 32'(imem_addr), 32'd8);
    chk("halt_hold_valid", 32'(valid_out), 32'd0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_valid", 32'(valid_out), 32'd0);
    step();
    chk("restart_pc", 32'(pc_out), 32'd0);
    chk("restart_vld", 32'(valid_out), 32'd1);
    step();
    chk("run_pc1", 32'(pc_out), 32'd1);

    // Start during RUN squashes and restarts
    Start = 1'b1;
    step();
    Start = 1'b0;
    chk("sq_valid", 32'(valid_out), 32'd0);
    chk("sq_addr", 32'(imem_addr), 32'd0);
    step();
    chk("sq_pc", 32'(pc_out), 32'd0);
    chk("sq_vld", 32'(valid_out), 32'd1);

    // Reset wins over an active stall
    stall_in = 1'b1;
    step();
    chk("stall_addr1", 32'(imem_addr), 32'd1);
    Reset = 1'b1;
    step();
    chk("rst_stall_valid", 32'(valid_out), 32'd0);
    chk("rst_stall_addr", 32'(imem_addr), 32'd0);
    chk("rst_stall_opnd", 32'(operand_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
